text_buffer_uart_writer: RTL and testbench



---
 rtl/text_buffer_pkg.sv | 22 ++
 rtl/uart_rx_core.sv | 134 +++++++++++++
 rtl/text_buffer_uart_writer.sv | 114 +++++++++++
 tb/tb_text_buffer_uart_writer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/text_buffer_pkg.sv
// Shared constants and rx FSM state type for the UART-fed text buffer.
package text_buffer_pkg;

    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_FF        = 8'h0C;
    localparam logic [7:0] ASCII_MAX_PRINT = 8'h7E;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } rx_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_SPACE) && (b <= ASCII_MAX_PRINT);
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, falling-edge start detect, bit timer and FSM.
// commit/commit_byte are combinational on the stop-sample cycle so the buffer lands with rx_valid.
module uart_rx_core
    import text_buffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 218
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       commit,
    output logic [7:0] commit_byte,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1_q, sync2_q, prev_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             valid_q, valid_d;
    logic [7:0]       byte_q, byte_d;
    logic             ferr_q, ferr_d;

    logic fall;
    logic tick;

    assign fall = prev_q & ~sync2_q;
    assign tick = (cnt_q == CNT_ONE);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        valid_d     = 1'b0;
        byte_d      = byte_q;
        ferr_d      = 1'b0;
        commit      = 1'b0;
        commit_byte = shift_q;

        if (state_q != IDLE && state_q != WAIT_IDLE && !tick) begin
            cnt_d = cnt_q - CNT_ONE;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    cnt_d   = HALF_BIT;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    if (!sync2_q) begin
                        cnt_d   = FULL_BIT;
                        bit_d   = 3'd0;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {sync2_q, shift_q[7:1]};
                    cnt_d   = FULL_BIT;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (sync2_q) begin
                        commit  = 1'b1;
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (sync2_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            valid_q <= 1'b0;
            byte_q  <= '0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            byte_q  <= byte_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid  = valid_q;
    assign rx_byte   = byte_q;
    assign frame_err = ferr_q;

endmodule

// File: rtl/text_buffer_uart_writer.sv
// UART-written character buffer read combinationally by the VGA text renderer.
// Define DOUBLE_BUFFER_EN for a back buffer copied to the displayed buffer on frame_start.
module text_buffer_uart_writer
    import text_buffer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 218,
    parameter int N_CHARS      = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       rx,
    input  logic                       frame_start,
    input  logic [$clog2(N_CHARS)-1:0] rd_col,
    output logic [7:0]                 rd_char,
    output logic [$clog2(N_CHARS)-1:0] cursor,
    output logic                       rx_valid,
    output logic [7:0]                 rx_byte,
    output logic                       frame_err
);

    localparam int CW = $clog2(N_CHARS);
    localparam logic [CW-1:0] CUR_ONE = CW'(1);

    logic       commit;
    logic [7:0] commit_byte;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .commit     (commit),
        .commit_byte(commit_byte),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    logic [7:0]    cell_q [N_CHARS];
    logic [7:0]    cell_d [N_CHARS];
    logic [CW-1:0] cursor_q, cursor_d;
    logic [CW-1:0] cursor_prev;

    assign cursor_prev = cursor_q - CUR_ONE;

    always_comb begin
        cell_d   = cell_q;
        cursor_d = cursor_q;
        if (commit) begin
            if (is_printable(commit_byte)) begin
                cell_d[cursor_q] = commit_byte;
                cursor_d         = cursor_q + CUR_ONE;
            end else if (commit_byte == ASCII_CR) begin
                cursor_d = '0;
            end else if (commit_byte == ASCII_BS) begin
                if (cursor_q != '0) begin
                    cursor_d            = cursor_prev;
                    cell_d[cursor_prev] = ASCII_SPACE;
                end
            end else if (commit_byte == ASCII_FF) begin
                for (int unsigned i = 0; i < N_CHARS; i++) begin
                    cell_d[i] = ASCII_SPACE;
                end
                cursor_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CHARS; i++) begin
                cell_q[i] <= ASCII_SPACE;
            end
            cursor_q <= '0;
        end else begin
            cell_q   <= cell_d;
            cursor_q <= cursor_d;
        end
    end

    assign cursor = cursor_q;

`ifdef DOUBLE_BUFFER_EN
    logic [7:0] front_q [N_CHARS];
    logic [7:0] front_d [N_CHARS];

    // Copy from cell_d, not cell_q, so a commit on the frame_start cycle is included.
    always_comb begin
        front_d = front_q;
        if (frame_start) begin
            front_d = cell_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CHARS; i++) begin
                front_q[i] <= ASCII_SPACE;
            end
        end else begin
            front_q <= front_d;
        end
    end

    assign rd_char = front_q[rd_col];
`else
    logic frame_start_unused;
    assign frame_start_unused = frame_start;

    assign rd_char = cell_q[rd_col];
`endif

endmodule

// File: tb/tb_text_buffer_uart_writer.sv
// Self-checking bench: directed vector table, corner-case sequences and random bytes vs a buffer model.
module tb_text_buffer_uart_writer;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       frame_start = 1'b0;
    logic [4:0] rd_col = '0;
    logic [7:0] rd_char;
    logic [4:0] cursor;
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       frame_err;

    text_buffer_uart_writer #(
        .CLKS_PER_BIT(CPB),
        .N_CHARS     (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .frame_start(frame_start),
        .rd_col     (rd_col),
        .rd_char    (rd_char),
        .cursor     (cursor),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int ferr_cnt = 0;
    int last_valid_cyc = 0;
    int stop_cyc = 0;
    bit mon_rd = 1'b1;
    bit fs_auto = 1'b1;

    // Reference model: screen contents and cursor per the byte rules.
    logic [7:0] m_cell [32];
    int         m_cur;
    logic [7:0] exp_q [$];

    function automatic void m_reset();
        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
        m_cur = 0;
    endfunction

    function automatic void m_apply(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            m_cell[m_cur] = b;
            m_cur = (m_cur + 1) % 32;
        end else if (b == 8'h0D) begin
            m_cur = 0;
        end else if (b == 8'h08) begin
            if (m_cur > 0) begin
                m_cur = m_cur - 1;
                m_cell[m_cur] = 8'h20;
            end
        end else if (b == 8'h0C) begin
            for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
            m_cur = 0;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // In the default build frame_start must be ignored, so it is toggled randomly;
    // with the double buffer it is held high so the front copy tracks every commit.
    always @(posedge clk) begin
        #1;
        if (fs_auto) begin
`ifdef DOUBLE_BUFFER_EN
            frame_start = 1'b1;
`else
            frame_start = 1'($urandom_range(0, 1));
`endif
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) ferr_cnt++;
            if (rx_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got rx_byte 0x%0h with no byte sent", rx_byte);
                end else begin
                    logic [7:0] b;
                    b = exp_q.pop_front();
                    chk("rx_byte", rx_byte, b);
                    m_apply(b);
                    chk("cursor_at_commit", cursor, m_cur);
                    if (mon_rd) chk("rd_char_at_commit", rd_char, m_cell[rd_col]);
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Leaves rx at the stop-bit level; caller returns the line to idle.
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        if (stop_bit) exp_q.push_back(b);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop_bit;
        stop_cyc = cyc;
        wait_cyc(CPB);
    endtask

    task automatic send_chk(input logic [7:0] b);
        int v0, f0, lat;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_byte(b, 1'b1);
        rx = 1'b1;
        wait_cyc(4);
        chk("valid_count", valid_cnt, v0 + 1);
        chk("no_frame_err", ferr_cnt, f0);
        lat = last_valid_cyc - stop_cyc;
        checks++;
        if (lat < 4 || lat > 15) begin
            errors++;
            $display("FAIL valid_timing: rx_valid %0d cycles into stop bit, expected 4..15", lat);
        end
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            rd_col = 5'(i);
            #1;
            chk(name, rd_char, m_cell[i]);
        end
    endtask

    typedef struct {
        logic [7:0] b;
        int         exp_cur;
        int         col;
        logic [7:0] exp_ch;
    } vec_t;

    vec_t vecs [20];

    initial begin
        int v0, f0;
        logic [4:0] cur0;

        vecs[0]  = '{8'h48, 1, 0, 8'h48};
        vecs[1]  = '{8'h49, 2, 1, 8'h49};
        vecs[2]  = '{8'h0C, 0, 0, 8'h20};
        vecs[3]  = '{8'h41, 1, 0, 8'h41};
        vecs[4]  = '{8'h42, 2, 1, 8'h42};
        vecs[5]  = '{8'h08, 1, 1, 8'h20};
        vecs[6]  = '{8'h08, 0, 0, 8'h20};
        vecs[7]  = '{8'h08, 0, 0, 8'h20};
        vecs[8]  = '{8'h0D, 0, 0, 8'h20};
        vecs[9]  = '{8'h5A, 1, 0, 8'h5A};
        vecs[10] = '{8'h01, 1, 1, 8'h20};
        vecs[11] = '{8'h7F, 1, 1, 8'h20};
        vecs[12] = '{8'h7E, 2, 1, 8'h7E};
        vecs[13] = '{8'h31, 3, 2, 8'h31};
        vecs[14] = '{8'h32, 4, 3, 8'h32};
        vecs[15] = '{8'h33, 5, 4, 8'h33};
        vecs[16] = '{8'h0C, 0, 4, 8'h20};
        vecs[17] = '{8'h0D, 0, 0, 8'h20};
        vecs[18] = '{8'hFF, 0, 0, 8'h20};
        vecs[19] = '{8'h20, 1, 0, 8'h20};

        m_reset();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(3);
        chk("reset_cursor", cursor, 0);
        chk("reset_rx_valid", rx_valid, 0);
        chk("reset_rx_byte", rx_byte, 0);
        chk("reset_frame_err", frame_err, 0);
        sweep("reset_cell");

        for (int i = 0; i < 20; i++) begin
            rd_col = 5'(vecs[i].col);
            send_chk(vecs[i].b);
            chk("vec_cursor", cursor, vecs[i].exp_cur);
            chk("vec_cell", rd_char, vecs[i].exp_ch);
        end
        sweep("after_vectors");

        send_chk(8'h0D);
        for (int c = 8'h41; c <= 8'h61; c++) send_chk(8'(c));
        chk("wrap_cursor", cursor, 1);
        rd_col = 5'd0; #1;
        chk("wrap_cell0", rd_char, 8'h61);
        rd_col = 5'd1; #1;
        chk("wrap_cell1", rd_char, 8'h42);
        rd_col = 5'd31; #1;
        chk("wrap_cell31", rd_char, 8'h60);

        // Bad stop bit followed by a long break.
        cur0 = cursor;
        v0 = valid_cnt;
        f0 = ferr_cnt;
        send_byte(8'h58, 1'b0);
        wait_cyc(40 * CPB);
        chk("break_ferr_pulses", ferr_cnt, f0 + 1);
        chk("break_no_valid", valid_cnt, v0);
        rx = 1'b1;
        wait_cyc(2 * CPB);
        chk("break_ferr_after_idle", ferr_cnt, f0 + 1);
        chk("break_valid_after_idle", valid_cnt, v0);
        chk("break_cursor", cursor, cur0);
        sweep("break_cell");
        send_chk(8'h4B);

        // Short low glitch must be rejected at the start-bit sample.
        v0 = valid_cnt;
        f0 = ferr_cnt;
        rx = 1'b0;
        wait_cyc(3);
        rx = 1'b1;
        wait_cyc(3 * CPB);
        chk("glitch_no_valid", valid_cnt, v0);
        chk("glitch_no_ferr", ferr_cnt, f0);
        chk("glitch_rx_byte_held", rx_byte, 8'h4B);

        for (int n = 0; n < 60; n++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 19);
            if (r == 0)      b = 8'h0D;
            else if (r < 3)  b = 8'h08;
            else if (r == 3) b = 8'h0C;
            else if (r < 6)  b = 8'($urandom_range(0, 255));
            else             b = 8'($urandom_range(32, 126));
            rd_col = 5'($urandom_range(0, 31));
            send_chk(b);
            if (n % 15 == 14) sweep("random_cell");
        end
        send_chk(8'h2A);

        // Reset in the middle of a frame.
        v0 = valid_cnt;
        rx = 1'b0;
        wait_cyc(CPB);
        rx = 1'b1;
        wait_cyc(3 * CPB);
        rst_n = 1'b0;
        rx = 1'b1;
        m_reset();
        exp_q.delete();
        wait_cyc(3);
        rst_n = 1'b1;
        wait_cyc(8 * CPB);
        chk("midreset_no_valid", valid_cnt, v0);
        chk("midreset_cursor", cursor, 0);
        sweep("midreset_cell");

        // Frame-synchronous visibility.
        send_chk(8'h0C);
        fs_auto = 1'b0;
        mon_rd = 1'b0;
        wait_cyc(1);
        frame_start = 1'b0;
        rd_col = 5'd0;
        send_chk(8'h51);
`ifdef DOUBLE_BUFFER_EN
        chk("db_before_frame", rd_char, 8'h20);
`else
        chk("sb_immediate", rd_char, 8'h51);
`endif
        frame_start = 1'b1;
        wait_cyc(1);
        frame_start = 1'b0;
        wait_cyc(1);
        chk("after_frame_start", rd_char, 8'h51);
        chk("final_cursor", cursor, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
